// File: rtl/sipo_capture_if.sv
// Serial capture bus: shift controls in, captured word and status out.
interface sipo_capture_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic             clr;
  logic             d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             perr;

  modport master (output en, clr, d, input q, qn, valid, count, perr);
  modport slave  (input en, clr, d, output q, qn, valid, count, perr);
endinterface

// File: rtl/sipo_capture.sv
// Serial-in/parallel-out word capture, MSB first, with 1-cycle valid strobe.
// Define SIPO_CAPTURE_PARITY_EN to append a trailing even-parity bit to each frame.
module sipo_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic           clk,
  input logic           rst,
  sipo_capture_if.slave bus
);
`ifdef SIPO_CAPTURE_PARITY_EN
  localparam int FLEN = WIDTH + 1;
  localparam int SW   = WIDTH;
`else
  // Without parity the last data bit goes straight to q, so shreg needs one bit less.
  localparam int FLEN = WIDTH;
  localparam int SW   = WIDTH - 1;
`endif

  logic [SW-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;
  logic             last;

`ifdef SIPO_CAPTURE_PARITY_EN
  logic perr_q, perr_d;
  assign shifted = {shreg_q[WIDTH-2:0], bus.d};
`else
  assign shifted = {shreg_q, bus.d};
`endif

  assign last = (count_q == CNT_W'(FLEN - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      count_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
`ifdef SIPO_CAPTURE_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
      q_q     <= q_d;
      valid_q <= valid_d;
`ifdef SIPO_CAPTURE_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next state: clr beats en, and the LAST slot wraps count while capturing q
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    q_d     = q_q;
    valid_d = 1'b0;
`ifdef SIPO_CAPTURE_PARITY_EN
    perr_d  = perr_q;
`endif
    if (bus.clr) begin
      shreg_d = '0;
      count_d = '0;
    end else if (bus.en) begin
      if (last) begin
        count_d = '0;
        valid_d = 1'b1;
`ifdef SIPO_CAPTURE_PARITY_EN
        q_d     = shreg_q;
        perr_d  = (^shreg_q) ^ bus.d;
`else
        q_d     = shifted;
`endif
      end else begin
        shreg_d = shifted[SW-1:0];
        count_d = count_q + 1'b1;
      end
    end
  end

  // Outputs: all registered, qn is a pure inversion of q
  always_comb begin
    bus.q     = q_q;
    bus.qn    = ~q_q;
    bus.valid = valid_q;
    bus.count = count_q;
`ifdef SIPO_CAPTURE_PARITY_EN
    bus.perr  = perr_q;
`else
    bus.perr  = 1'b0;
`endif
  end
endmodule
